// File: rtl/csp_pkg.sv
// Shared definitions for the circular scratchpad: default geometry, count type
// and a ceiling-log2 helper used to size counters.
package csp_pkg;

   localparam int CSP_DATA_WIDTH = 16;
   localparam int CSP_ADDR_WIDTH = 3;
   localparam int CSP_PAR_WRITE  = 2;
   localparam int CSP_PAR_READ   = 1;

   typedef logic [CSP_ADDR_WIDTH:0] csp_count_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 32'sd1;
      while (v > 32'sd0) begin
         res = res + 32'sd1;
         v   = v >>> 32'sd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/csp_ptr_ctrl.sv
// Pointer, occupancy and accept control for circular_scratchpad.
// Optional sticky ovf_err/udf_err outputs exist when CSP_ERR_FLAGS_EN is defined.
module csp_ptr_ctrl
   import csp_pkg::*;
#(
   parameter int ADDR_WIDTH = CSP_ADDR_WIDTH,
   parameter int PAR_WRITE  = CSP_PAR_WRITE,
   parameter int PAR_READ   = CSP_PAR_READ
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  chip_en,
   input  logic                  flush,
   input  logic                  wen,
   input  logic                  ren,
   output logic [ADDR_WIDTH-1:0] wptr,
   output logic [ADDR_WIDTH-1:0] rptr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  wready,
   output logic                  rready,
   output logic                  full,
   output logic                  empty,
   output logic                  wr_acc,
   output logic                  rd_acc
`ifdef CSP_ERR_FLAGS_EN
   ,
   output logic                  ovf_err,
   output logic                  udf_err
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      PW_C    = CNT_W'(PAR_WRITE);
   localparam logic [CNT_W-1:0]      PR_C    = CNT_W'(PAR_READ);
   localparam logic [ADDR_WIDTH-1:0] PW_STEP = ADDR_WIDTH'(PAR_WRITE);
   localparam logic [ADDR_WIDTH-1:0] PR_STEP = ADDR_WIDTH'(PAR_READ);

   logic [ADDR_WIDTH-1:0] wptr_r;
   logic [ADDR_WIDTH-1:0] rptr_r;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      count_nxt_s;
   logic [CNT_W-1:0]      free_s;
   logic                  wready_s;
   logic                  rready_s;
   logic                  flush_s;
   logic                  wacc_s;
   logic                  racc_s;

   // Flags come from the registered count only; requests never feed back into them.
   always_comb begin
      free_s   = DEPTH_C - count_r;
      wready_s = (free_s >= PW_C);
      rready_s = (count_r >= PR_C);
      flush_s  = chip_en & flush;
      wacc_s   = wen & chip_en & wready_s & ~flush;
      racc_s   = ren & chip_en & rready_s & ~flush;
      if (wacc_s && racc_s) begin
         count_nxt_s = count_r + PW_C - PR_C;
      end else if (wacc_s) begin
         count_nxt_s = count_r + PW_C;
      end else if (racc_s) begin
         count_nxt_s = count_r - PR_C;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Pointer and occupancy state; flush outranks any same-cycle access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else if (flush_s) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (wacc_s) begin
            wptr_r <= wptr_r + PW_STEP;
         end
         if (racc_s) begin
            rptr_r <= rptr_r + PR_STEP;
         end
         count_r <= count_nxt_s;
      end
   end

`ifdef CSP_ERR_FLAGS_EN
   logic ovf_err_r;
   logic udf_err_r;

   // Sticky record of refused requests, cleared only by flush or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err_r <= 1'b0;
         udf_err_r <= 1'b0;
      end else if (flush_s) begin
         ovf_err_r <= 1'b0;
         udf_err_r <= 1'b0;
      end else begin
         if (wen && chip_en && !wready_s) begin
            ovf_err_r <= 1'b1;
         end
         if (ren && chip_en && !rready_s) begin
            udf_err_r <= 1'b1;
         end
      end
   end

   assign ovf_err = ovf_err_r;
   assign udf_err = udf_err_r;
`endif

   assign wptr   = wptr_r;
   assign rptr   = rptr_r;
   assign count  = count_r;
   assign wready = wready_s;
   assign rready = rready_s;
   assign full   = (count_r == DEPTH_C);
   assign empty  = (count_r == {CNT_W{1'b0}});
   assign wr_acc = wacc_s;
   assign rd_acc = racc_s;

endmodule

// File: rtl/circular_scratchpad.sv
// Circular scratchpad: PAR_WRITE words pushed per write, PAR_READ words popped per read.
// Define CSP_ERR_FLAGS_EN to add sticky ovf_err/udf_err outputs.
module circular_scratchpad
   import csp_pkg::*;
#(
   parameter int DATA_WIDTH = CSP_DATA_WIDTH,
   parameter int ADDR_WIDTH = CSP_ADDR_WIDTH,
   parameter int PAR_WRITE  = CSP_PAR_WRITE,
   parameter int PAR_READ   = CSP_PAR_READ
)
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           chip_en,
   input  logic                           flush,
   input  logic                           wen,
   input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
   output logic                           wready,
   input  logic                           ren,
   output logic                           rready,
   output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
   output logic                           dout_valid,
   output logic [ADDR_WIDTH:0]             count,
   output logic                           full,
   output logic                           empty
`ifdef CSP_ERR_FLAGS_EN
   ,
   output logic                           ovf_err,
   output logic                           udf_err
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (PAR_WRITE > DEPTH || PAR_WRITE < 1) begin : g_bad_par_write
      $error("circular_scratchpad: PAR_WRITE=%0d outside 1..%0d", PAR_WRITE, DEPTH);
   end
   if (PAR_READ > DEPTH || PAR_READ < 1) begin : g_bad_par_read
      $error("circular_scratchpad: PAR_READ=%0d outside 1..%0d", PAR_READ, DEPTH);
   end

   logic [ADDR_WIDTH-1:0]          wptr_s;
   logic [ADDR_WIDTH-1:0]          rptr_s;
   logic                           wr_acc_s;
   logic                           rd_acc_s;
   logic [DATA_WIDTH-1:0]          mem_r [DEPTH];
   logic [PAR_READ*DATA_WIDTH-1:0] dout_r;
   logic                           dout_valid_r;

   csp_ptr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PAR_WRITE  (PAR_WRITE),
      .PAR_READ   (PAR_READ)
   ) u_ptr_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .chip_en (chip_en),
      .flush   (flush),
      .wen     (wen),
      .ren     (ren),
      .wptr    (wptr_s),
      .rptr    (rptr_s),
      .count   (count),
      .wready  (wready),
      .rready  (rready),
      .full    (full),
      .empty   (empty),
      .wr_acc  (wr_acc_s),
      .rd_acc  (rd_acc_s)
`ifdef CSP_ERR_FLAGS_EN
      ,
      .ovf_err (ovf_err),
      .udf_err (udf_err)
`endif
   );

   // Storage is not reset; indices wrap naturally so a burst may straddle the end.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         for (int i = 0; i < PAR_WRITE; i++) begin
            mem_r[wptr_s + ADDR_WIDTH'(i)] <= din[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   // Read register samples pre-write storage, so there is no write-to-read bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
      end else begin
         dout_valid_r <= rd_acc_s;
         if (rd_acc_s) begin
            for (int j = 0; j < PAR_READ; j++) begin
               dout_r[DATA_WIDTH*j +: DATA_WIDTH] <= mem_r[rptr_s + ADDR_WIDTH'(j)];
            end
         end
      end
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_circular_scratchpad.sv
// Directed, scoreboarded bench for circular_scratchpad (DEPTH=8, PAR_WRITE=2, PAR_READ=1).
module tb_circular_scratchpad;
   import csp_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int PW    = 2;
   localparam int PR    = 1;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             chip_en;
   logic             flush;
   logic             wen;
   logic             ren;
   logic [PW*DW-1:0] din;
   logic             wready;
   logic             rready;
   logic [PR*DW-1:0] dout;
   logic             dout_valid;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
`ifdef CSP_ERR_FLAGS_EN
   logic             ovf_err;
   logic             udf_err;
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mq [$];
   logic [DW-1:0] sb [$];
   logic [DW-1:0] last_dout = '0;
   logic [DW-1:0] exp_list [6];

   always #5 clk = ~clk;

   circular_scratchpad #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .PAR_WRITE  (PW),
      .PAR_READ   (PR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .chip_en    (chip_en),
      .flush      (flush),
      .wen        (wen),
      .din        (din),
      .wready     (wready),
      .ren        (ren),
      .rready     (rready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .count      (count),
      .full       (full),
      .empty      (empty)
`ifdef CSP_ERR_FLAGS_EN
      ,
      .ovf_err    (ovf_err),
      .udf_err    (udf_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: flags checked before the edge, results after it.
   task automatic step(input logic w, input logic [31:0] d, input logic r,
                       input logic f, input logic ce, input string tag);
      logic wacc;
      logic racc;
      int   n;
      @(negedge clk);
      wen = w; din = d; ren = r; flush = f; chip_en = ce;
      #1;
      n = mq.size();
      chk({tag, ":count_pre"}, 32'(count), 32'(n));
      chk({tag, ":wready"}, 32'(wready), 32'(DEPTH - n >= PW));
      chk({tag, ":rready"}, 32'(rready), 32'(n >= PR));
      chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
      wacc = w & ce & (DEPTH - n >= PW) & ~f;
      racc = r & ce & (n >= PR) & ~f;
      if (f && ce) begin
         mq.delete();
`ifdef CSP_ERR_FLAGS_EN
         m_ovf = 1'b0;
         m_udf = 1'b0;
`endif
      end else begin
         if (racc) sb.push_back(mq.pop_front());
         if (wacc) begin
            mq.push_back(d[15:0]);
            mq.push_back(d[31:16]);
         end
`ifdef CSP_ERR_FLAGS_EN
         if (w && ce && !(DEPTH - n >= PW)) m_ovf = 1'b1;
         if (r && ce && !(n >= PR)) m_udf = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
      chk({tag, ":dout_valid"}, 32'(dout_valid), 32'(racc));
      if (racc) last_dout = sb.pop_front();
      chk({tag, ":dout"}, 32'(dout), 32'(last_dout));
      chk({tag, ":count_post"}, 32'(count), 32'(mq.size()));
`ifdef CSP_ERR_FLAGS_EN
      chk({tag, ":ovf_err"}, 32'(ovf_err), 32'(m_ovf));
      chk({tag, ":udf_err"}, 32'(udf_err), 32'(m_udf));
`endif
   endtask

   task automatic idle_inputs();
      wen = 1'b0; ren = 1'b0; flush = 1'b0; chip_en = 1'b1; din = '0;
   endtask

   task automatic clear_model();
      mq.delete();
      sb.delete();
      last_dout = '0;
`ifdef CSP_ERR_FLAGS_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      #12;
      chk("reset:count", 32'(count), 32'd0);
      chk("reset:empty", 32'(empty), 32'd1);
      chk("reset:full", 32'(full), 32'd0);
      chk("reset:wready", 32'(wready), 32'd1);
      chk("reset:rready", 32'(rready), 32'd0);
      chk("reset:dout", 32'(dout), 32'd0);
      chk("reset:dout_valid", 32'(dout_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full, then a refused fifth write.
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, {16'(2 * k), 16'(2 * k - 1)}, 1'b0, 1'b0, 1'b1, "fill");
      end
      step(1'b1, 32'h00FF_00EE, 1'b0, 1'b0, 1'b1, "fill_refused");
      chk("fill:count8", 32'(count), 32'd8);
      chk("fill:full", 32'(full), 32'd1);
      chk("fill:wready", 32'(wready), 32'd0);

      // Ordered drain with one extra request past empty.
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "drain");
         chk("drain:value", 32'(dout), 32'(k));
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "drain_refused");
      chk("drain:valid9", 32'(dout_valid), 32'd0);
      chk("drain:hold", 32'(dout), 32'h0008);
      chk("drain:empty", 32'(empty), 32'd1);

      // Pointers wrap past the end of storage.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, {16'(16'h0100 + 2 * k + 1), 16'(16'h0100 + 2 * k)}, 1'b0, 1'b0, 1'b1, "wrap_fill");
      end
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "wrap_read");
      end
      step(1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0, 1'b1, "wrap_ab0");
      step(1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0, 1'b1, "wrap_ab1");
      step(1'b1, 32'hDDDD_CCCC, 1'b0, 1'b0, 1'b1, "wrap_cd");
      exp_list = '{16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "wrap_drain");
         chk("wrap:value", 32'(dout), 32'(exp_list[k]));
      end

      // Simultaneous read and write, including a refused write while full.
      step(1'b1, 32'h0202_0101, 1'b0, 1'b0, 1'b1, "sim_w0");
      step(1'b1, 32'h0404_0303, 1'b0, 1'b0, 1'b1, "sim_w1");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "sim_r0");
      step(1'b1, 32'h0606_0505, 1'b1, 1'b0, 1'b1, "sim_rw");
      chk("sim:count4", 32'(count), 32'd4);
      chk("sim:oldest", 32'(dout), 32'h0202);
      step(1'b1, 32'h0808_0707, 1'b0, 1'b0, 1'b1, "sim_w2");
      step(1'b1, 32'h0A0A_0909, 1'b0, 1'b0, 1'b1, "sim_w3");
      step(1'b1, 32'h0C0C_0B0B, 1'b1, 1'b0, 1'b1, "sim_full_rw");
      chk("sim:full_rw_count", 32'(count), 32'd7);
      chk("sim:full_rw_dout", 32'(dout), 32'h0303);

      // chip_en low masks everything, then flush wins over wen/ren.
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "pre_flush_r0");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "pre_flush_r1");
      step(1'b1, 32'h0E0E_0D0D, 1'b1, 1'b1, 1'b0, "chip_dis");
      chk("chip_dis:count5", 32'(count), 32'd5);
      step(1'b1, 32'h0E0E_0D0D, 1'b1, 1'b1, 1'b1, "flush");
      chk("flush:count", 32'(count), 32'd0);
      chk("flush:valid", 32'(dout_valid), 32'd0);
      chk("flush:empty", 32'(empty), 32'd1);
      chk("flush:dout_hold", 32'(dout), 32'h0505);

      // Asynchronous reset in the middle of a drain.
      step(1'b1, 32'h2222_1111, 1'b0, 1'b0, 1'b1, "rst_w0");
      step(1'b1, 32'h4444_3333, 1'b0, 1'b0, 1'b1, "rst_w1");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "rst_r0");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "rst_r1");
      #2;
      rst_n = 1'b0;
      #1;
      clear_model();
      chk("async_rst:count", 32'(count), 32'd0);
      chk("async_rst:dout", 32'(dout), 32'd0);
      chk("async_rst:valid", 32'(dout_valid), 32'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      step(1'b1, 32'h5678_1234, 1'b0, 1'b0, 1'b1, "post_rst_w");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "post_rst_r");
      chk("post_rst:index0", 32'(dout), 32'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
